// File: rtl/spram_pkg.sv
// Shared types and helpers for the masked single-port RAM wrapper.
package spram_pkg;

  typedef enum logic [0:0] {
    StIdle,
    StRmwWr
  } state_e;

  // Upper bounds for the mask expansion helper; the wrapper slices down to DWIDTH.
  localparam int unsigned MaxDw    = 256;
  localparam int unsigned MaxLanes = 256;
  localparam int unsigned DwIdxW   = $clog2(MaxDw);
  localparam int unsigned LaneIdxW = $clog2(MaxLanes);

  // Expand a per-lane write mask into a per-bit mask; bit b follows lane b / lane_w.
  function automatic logic [MaxDw-1:0] expand_mask(input logic [MaxLanes-1:0] lane_mask,
                                                   input int unsigned lane_w);
    logic [MaxDw-1:0] bits;
    bits = '0;
    for (int unsigned b = 0; b < MaxDw; b++) begin
      bits[DwIdxW'(b)] = lane_mask[LaneIdxW'(b / lane_w)];
    end
    return bits;
  endfunction

endpackage

// File: rtl/spram_masked_rmw_if.sv
// Request/response bundle of the masked single-port RAM wrapper.
interface spram_masked_rmw_if #(
  parameter int unsigned AWIDTH    = 11,
  parameter int unsigned DWIDTH    = 60,
  parameter int unsigned NUM_LANES = 6
);
  logic                 req_valid;
  logic                 req_ready;
  logic                 req_we;
  logic [AWIDTH-1:0]    req_addr;
  logic [DWIDTH-1:0]    req_wdata;
  logic [NUM_LANES-1:0] req_mask;
  logic                 rd_valid;
  logic [DWIDTH-1:0]    rd_data;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_mask,
    input  req_ready, rd_valid, rd_data
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_mask,
    output req_ready, rd_valid, rd_data
  );
endinterface

// File: rtl/single_port_ram.sv
// Behavioural stand-in for the foundry single_port_ram macro (no byte enables,
// registered read, read-before-write), used when the vendor library is absent.
module single_port_ram #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic                  we,
  input  logic [DATA_WIDTH-1:0] data,
  output logic [DATA_WIDTH-1:0] out
);
  logic [DATA_WIDTH-1:0] mem_q [2**ADDR_WIDTH];

  // Synchronous write and registered read of the addressed word.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[addr] <= data;
    end
    out <= mem_q[addr];
  end
endmodule

// File: rtl/spram_core.sv
// Storage primitive: behavioural array or the single_port_ram macro, same timing.
module spram_core #(
  parameter int unsigned AWIDTH    = 11,
  parameter int unsigned NUM_WORDS = 2048,
  parameter int unsigned DWIDTH    = 60
) (
  input  logic              clk_i,
  input  logic [AWIDTH-1:0] addr_i,
  input  logic              we_i,
  input  logic [DWIDTH-1:0] wdata_i,
  output logic [DWIDTH-1:0] rdata_o
);

`ifdef SIMULATION_MEMORY
  logic [DWIDTH-1:0] mem_q [NUM_WORDS];
  logic [DWIDTH-1:0] rdata_q;

  // Registered read returns the pre-write contents, matching the macro.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
    rdata_q <= mem_q[addr_i];
  end

  assign rdata_o = rdata_q;
`else
  single_port_ram #(
    .ADDR_WIDTH(AWIDTH),
    .DATA_WIDTH(DWIDTH)
  ) u_ram (
    .clk (clk_i),
    .addr(addr_i),
    .we  (we_i),
    .data(wdata_i),
    .out (rdata_o)
  );
`endif

  // Words at or above NUM_WORDS do not exist; catch stray accesses in simulation.
  addr_in_range_a : assert property (@(posedge clk_i)
    ({1'b0, addr_i} < (AWIDTH + 1)'(NUM_WORDS)));

endmodule

// File: rtl/spram_masked_rmw.sv
// Single-port RAM wrapper with lane write masks; partial masks run as read-modify-write.
module spram_masked_rmw
  import spram_pkg::*;
#(
  parameter int unsigned AWIDTH    = 11,
  parameter int unsigned NUM_WORDS = 2048,
  parameter int unsigned DWIDTH    = 60,
  parameter int unsigned LANE_W    = 10,
  parameter int unsigned OUT_REG   = 1
) (
  input logic                clk_i,
  input logic                reset_i,
  spram_masked_rmw_if.slave  bus
);
  localparam int unsigned NumLanes = DWIDTH / LANE_W;

  state_e              state_q, state_d;
  logic [AWIDTH-1:0]   addr_q;
  logic [DWIDTH-1:0]   wdata_q;
  logic [NumLanes-1:0] mask_q;
  logic                rd_v1_q;

  logic                accept, mask_full, mask_none, rmw_start, rd_accept;
  logic                mem_we;
  logic [AWIDTH-1:0]   mem_addr;
  logic [DWIDTH-1:0]   mem_wdata, mem_rdata, merged, bit_mask;
  logic [MaxDw-1:0]    bit_mask_full;
  logic                unused_mask_bits;

  assign bus.req_ready = (state_q == StIdle) && !reset_i;
  assign accept        = bus.req_valid && bus.req_ready;
  assign mask_full     = &bus.req_mask;
  assign mask_none     = ~|bus.req_mask;
  assign rmw_start     = accept && bus.req_we && !mask_full && !mask_none;
  assign rd_accept     = accept && !bus.req_we;

  assign bit_mask_full    = expand_mask(MaxLanes'(mask_q), LANE_W);
  assign bit_mask         = bit_mask_full[DWIDTH-1:0];
  assign unused_mask_bits = ^bit_mask_full[MaxDw-1:DWIDTH];
  assign merged           = (wdata_q & bit_mask) | (mem_rdata & ~bit_mask);

  // Next state and memory port selection: request path in IDLE, merge write in RMW_WR.
  always_comb begin
    state_d   = state_q;
    mem_addr  = bus.req_addr;
    mem_we    = 1'b0;
    mem_wdata = bus.req_wdata;
    unique case (state_q)
      StIdle: begin
        mem_we = accept && bus.req_we && mask_full;
        if (rmw_start) begin
          state_d = StRmwWr;
        end
      end
      StRmwWr: begin
        mem_addr  = addr_q;
        mem_we    = 1'b1;
        mem_wdata = merged;
        state_d   = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // FSM state and latched partial-write request.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= StIdle;
      addr_q  <= '0;
      wdata_q <= '0;
      mask_q  <= '0;
    end else begin
      state_q <= state_d;
      if (rmw_start) begin
        addr_q  <= bus.req_addr;
        wdata_q <= bus.req_wdata;
        mask_q  <= bus.req_mask;
      end
    end
  end

  // Marks the cycle the macro output holds a user read result.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      rd_v1_q <= 1'b0;
    end else begin
      rd_v1_q <= rd_accept;
    end
  end

  spram_core #(
    .AWIDTH   (AWIDTH),
    .NUM_WORDS(NUM_WORDS),
    .DWIDTH   (DWIDTH)
  ) u_core (
    .clk_i  (clk_i),
    .addr_i (mem_addr),
    .we_i   (mem_we),
    .wdata_i(mem_wdata),
    .rdata_o(mem_rdata)
  );

  if (OUT_REG != 0) begin : g_out_reg
    logic              rd_v2_q;
    logic [DWIDTH-1:0] rd_data_q;

    // Output stage captures user reads only, so RMW reads leave rd_data alone.
    always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
        rd_v2_q   <= 1'b0;
        rd_data_q <= '0;
      end else begin
        rd_v2_q <= rd_v1_q;
        if (rd_v1_q) begin
          rd_data_q <= mem_rdata;
        end
      end
    end

    assign bus.rd_valid = rd_v2_q;
    assign bus.rd_data  = rd_data_q;
  end else begin : g_no_out_reg
    assign bus.rd_valid = rd_v1_q;
    assign bus.rd_data  = mem_rdata;
  end

endmodule

// File: tb/tb_spram_masked_rmw.sv
// Bench: drives one request stream into OUT_REG=0 and OUT_REG=1 instances and
// scoreboards each read response against hand-computed data and arrival cycle.
module tb_spram_masked_rmw;
  localparam int unsigned AW = 11;
  localparam int unsigned DW = 60;
  localparam int unsigned NL = 6;

  typedef struct {
    logic [DW-1:0] data;
    int unsigned   cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic          req_valid = 1'b0;
  logic          req_we    = 1'b0;
  logic [AW-1:0] req_addr  = '0;
  logic [DW-1:0] req_wdata = '0;
  logic [NL-1:0] req_mask  = '0;

  spram_masked_rmw_if #(.AWIDTH(AW), .DWIDTH(DW), .NUM_LANES(NL)) bus0 ();
  spram_masked_rmw_if #(.AWIDTH(AW), .DWIDTH(DW), .NUM_LANES(NL)) bus1 ();

  assign bus0.req_valid = req_valid;
  assign bus0.req_we    = req_we;
  assign bus0.req_addr  = req_addr;
  assign bus0.req_wdata = req_wdata;
  assign bus0.req_mask  = req_mask;
  assign bus1.req_valid = req_valid;
  assign bus1.req_we    = req_we;
  assign bus1.req_addr  = req_addr;
  assign bus1.req_wdata = req_wdata;
  assign bus1.req_mask  = req_mask;

  spram_masked_rmw #(.AWIDTH(AW), .NUM_WORDS(2048), .DWIDTH(DW), .LANE_W(10), .OUT_REG(0))
    dut0 (.clk_i(clk), .reset_i(rst), .bus(bus0));
  spram_masked_rmw #(.AWIDTH(AW), .NUM_WORDS(2048), .DWIDTH(DW), .LANE_W(10), .OUT_REG(1))
    dut1 (.clk_i(clk), .reset_i(rst), .bus(bus1));

  exp_t          q0[$];
  exp_t          q1[$];
  int            n_cmp   = 0;
  int            n_err   = 0;
  logic [DW-1:0] last_rd = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [DW-1:0] pat(input int i);
    return 60'h111111111111111 * 60'(i);
  endfunction

  // Present a request at a negedge, hold until accepted, return after the accepting edge.
  task automatic do_req(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                        input logic [NL-1:0] m, input logic [DW-1:0] exp,
                        output int unsigned t);
    int unsigned waited;
    waited = 0;
    @(negedge clk);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = a;
    req_wdata = wd;
    req_mask  = m;
    while (!(bus0.req_ready && bus1.req_ready) && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    t = cyc;
    if (waited >= 20) begin
      n_cmp++;
      n_err++;
      $display("FAIL req_accept_timeout: got no accept want accept within 20 cycles");
    end else begin
      if (!we) begin
        q0.push_back('{exp, cyc + 1});
        q1.push_back('{exp, cyc + 2});
        last_rd = exp;
      end
      @(posedge clk);
    end
  endtask

  task automatic idle();
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  // Monitors: every rd_valid pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && bus0.rd_valid) begin
      if (q0.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL rd0_unexpected: got rd_valid at cycle %0d want none", cyc);
      end else begin
        e = q0.pop_front();
        chk("rd0_data", 64'(bus0.rd_data), 64'(e.data));
        chk("rd0_cycle", 64'(cyc), 64'(e.cyc));
      end
    end
    if (!rst && bus1.rd_valid) begin
      if (q1.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL rd1_unexpected: got rd_valid at cycle %0d want none", cyc);
      end else begin
        e = q1.pop_front();
        chk("rd1_data", 64'(bus1.rd_data), 64'(e.data));
        chk("rd1_cycle", 64'(cyc), 64'(e.cyc));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish want finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned t, t2, w;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("reset_ready0", 64'(bus0.req_ready), 64'd1);
    chk("reset_ready1", 64'(bus1.req_ready), 64'd1);
    chk("reset_rd_valid0", 64'(bus0.rd_valid), 64'd0);
    chk("reset_rd_valid1", 64'(bus1.rd_valid), 64'd0);
    chk("reset_rd_data1", 64'(bus1.rd_data), 64'd0);

    // Full-mask write then read of the same word; no stall in between.
    do_req(1'b1, 11'd5, 60'hABC, 6'b111111, '0, t);
    do_req(1'b0, 11'd5, '0, '0, 60'hABC, t2);
    chk("t1_no_stall", 64'(t2), 64'(t + 1));
    idle();

    // Lane-0 partial write: one stall cycle, lane 0 cleared.
    do_req(1'b1, 11'd7, 60'h0FFFFFFFFFFFFFF, 6'b111111, '0, t);
    do_req(1'b1, 11'd7, 60'h0, 6'b000001, '0, t);
    @(negedge clk);
    req_valid = 1'b0;
    chk("t2_ready_low", 64'(bus0.req_ready), 64'd0);
    @(negedge clk);
    chk("t2_ready_back", 64'(bus0.req_ready), 64'd1);
    do_req(1'b0, 11'd7, '0, '0, 60'h0FFFFFFFFFFFC00, t);
    idle();

    // Back-to-back writes then reads of words 0..15.
    for (int i = 0; i < 16; i++) do_req(1'b1, AW'(i), pat(i), 6'b111111, '0, t);
    for (int i = 0; i < 16; i++) do_req(1'b0, AW'(i), '0, '0, pat(i), t);
    idle();
    repeat (4) @(negedge clk);

    // Partial write to word 3 with a read held behind it.
    do_req(1'b1, 11'd3, 60'hCCCCCCCCCCCCCCC, 6'b100001, '0, t);
    @(negedge clk);
    req_we   = 1'b0;
    req_addr = 11'd3;
    chk("t4_ready_low", 64'(bus1.req_ready), 64'd0);
    chk("t4_rd_data_hold", 64'(bus1.rd_data), 64'(last_rd));
    do_req(1'b0, 11'd3, '0, '0, 60'hCCF3333333330CC, t2);
    chk("t4_read_accept_cycle", 64'(t2), 64'(t + 2));
    idle();
    repeat (3) @(negedge clk);

    // Reset during the RMW write cycle drops the write.
    do_req(1'b1, 11'd9, 60'h123, 6'b111111, '0, t);
    do_req(1'b1, 11'd9, 60'hFFFFFFFFFFFFFFF, 6'b000001, '0, t);
    @(negedge clk);
    req_valid = 1'b0;
    rst       = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("t5_ready0", 64'(bus0.req_ready), 64'd1);
    chk("t5_ready1", 64'(bus1.req_ready), 64'd1);
    chk("t5_rd_valid0", 64'(bus0.rd_valid), 64'd0);
    chk("t5_rd_valid1", 64'(bus1.rd_valid), 64'd0);
    chk("t5_rd_data1", 64'(bus1.rd_data), 64'd0);
    do_req(1'b0, 11'd9, '0, '0, 60'h123, t);
    idle();

    // Zero-mask write: accepted in one cycle, word untouched.
    do_req(1'b1, 11'd2, 60'h55, 6'b111111, '0, t);
    do_req(1'b1, 11'd2, 60'hFFFFFFFFFFFFFFF, 6'b000000, '0, t);
    do_req(1'b0, 11'd2, '0, '0, 60'h55, t2);
    chk("t6_zero_mask_one_cycle", 64'(t2), 64'(t + 1));
    idle();

    w = 0;
    while ((q0.size() != 0 || q1.size() != 0) && w < 20) begin
      @(negedge clk);
      w++;
    end
    chk("queues_drained", 64'(q0.size() + q1.size()), 64'd0);
    repeat (3) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/spram_masked_rmw.md
Name: spram_masked_rmw

Overview:
Parametrised single-port RAM with a request/valid handshake, a configurable output register, and per-lane write masking.
The underlying single_port_ram macro has no byte enables, so partial-mask writes run as an internal read-modify-write sequence.
The block is the generic next-generation storage wrapper for buffers in the accelerator datapaths.
It replaces fixed-size single-port RAM wrappers with one parametrised block.

Parameters:
AWIDTH, 11, address width; depth is NUM_WORDS.
NUM_WORDS, 2048, words stored; must be at most 2**AWIDTH.
DWIDTH, 60, data width.
LANE_W, 10, bits per mask lane; DWIDTH must be divisible by LANE_W; NUM_LANES = DWIDTH/LANE_W.
OUT_REG, 1, 0 or 1; adds one output pipeline stage when 1.

Ports:
clk  input  1  clock, rising edge.
reset  input  1  asynchronous, active-high reset.
req_valid  input  1  request present.
req_ready  output  1  block can accept a request this cycle.
req_we  input  1  1 = write, 0 = read.
req_addr  input  AWIDTH  word address.
req_wdata  input  DWIDTH  write data.
req_mask  input  NUM_LANES  lane write enables; bit i covers bits [i*LANE_W +: LANE_W].
rd_valid  output  1  one-cycle pulse; rd_data is valid in that cycle.
rd_data  output  DWIDTH  read data.

Behaviour:
- Reset values: FSM in IDLE, req_ready=1 after release, rd_valid=0, rd_data=0 when OUT_REG=1. Memory contents are not cleared.
- Accept condition: req_valid && req_ready. No request is accepted while req_ready=0; the requester holds its inputs.
- FSM states: IDLE and RMW_WR.
  - IDLE: req_ready=1.
  - RMW_WR: req_ready=0; lasts exactly 1 cycle, then returns to IDLE.
- Read accepted in cycle T: memory read at the T edge.
  - OUT_REG=0: rd_valid=1 and rd_data valid in T+1.
  - OUT_REG=1: rd_valid=1 and rd_data valid in T+2.
  - Back-to-back reads give one result per cycle.
- Write with mask all ones: direct write at the T edge; no rd_valid; stays in IDLE.
- Write with mask all zeros: accepted, memory untouched, no rd_valid.
- Write with a partial mask, accepted in T:
  - Internal read of req_addr at the T edge.
  - Address, wdata and mask are latched; FSM goes to RMW_WR.
  - In T+1, merged word = masked lanes from latched wdata, other lanes from memory output. It is written at the T+1 edge.
  - FSM returns to IDLE at T+2. Total occupancy is 2 cycles.
  - No rd_valid is produced.
- Memory we is a function of registered state and the accepted request only. No write is issued in a cycle where reset is asserted.
- rd_data stability:
  - OUT_REG=1: rd_data holds the last user read result until the next rd_valid; RMW internal reads never disturb it.
  - OUT_REG=0: rd_data is the raw macro output and is defined only while rd_valid=1.
- Read after write: a read accepted in the cycle after a write completes to the same address returns the new data. This includes a read accepted at T+2 after an RMW.
- Reset mid-RMW, asserted during RMW_WR: the pending write is dropped, the memory word is unchanged, and the FSM is IDLE on release.
- Reset mid-read: in-flight rd_valid pulses are cancelled.
- Addresses at or above NUM_WORDS: behaviour undefined; the bench never drives them.
- SIMULATION_MEMORY defined: behavioural array. Otherwise: single_port_ram with ADDR_WIDTH/DATA_WIDTH overridden from parameters. Both paths have identical cycle timing.

Decomposition:
- Package spram_pkg: FSM state encoding (IDLE, RMW_WR), and a function that expands a lane mask to a DWIDTH bit mask.
- Sub-module spram_core: clk/addr/we/data/out storage primitive. It wraps the SIMULATION_MEMORY behavioural array vs the single_port_ram instance.
- The top level holds the FSM, merge logic, valid pipeline and optional output register.

Test Plan:
1. OUT_REG=1: write 0xABC to addr 5 with mask all ones, then read addr 5 → rd_valid two cycles after read accept, rd_data=0xABC, req_ready never drops.
2. Preload addr 7 = 0x0FFFFFFFFFFFFFF; write 0 with mask 6'b000001 → req_ready low exactly 1 cycle; later read addr 7 returns 0x0FFFFFFFFFFFC00.
3. Back-to-back reads of addrs 0..15 with OUT_REG=0 and OUT_REG=1 → 16 consecutive rd_valid pulses in order, latency 1 and 2 respectively.
4. Partial-mask write to addr 3 followed immediately by read of addr 3 (held while req_ready=0) → read accepted at T+2, returns merged data; rd_data (OUT_REG=1) unchanged during the RMW.
5. Assert reset during the RMW_WR cycle of a partial write to addr 9 holding 0x123 → after release, read addr 9 returns 0x123, rd_valid=0 and req_ready=1 immediately after reset.
6. Write with mask 0 to addr 2 holding 0x55 → accepted in one cycle, read returns 0x55, no rd_valid for the write.
